pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Front-end sequencer for the 5-stage DLX pipeline. Drives the PC write enable, IF/ID
//  write/flush and ID/EX bubble controls for the instruction fetch stage.
//  Resolves load-use hazards, taken jumps/branches and multi-cycle instruction-memory
//  fetches. Keeps a saturating stall counter and a sticky fetch-timeout flag.
// PARAMETERS
//  STALL_CNT_W    16  width of StallCount.
//  MAX_IMEM_WAIT  15  WAIT-state cycles without IMemReady before timeout (>=1).
// PORTS
//  clk          in   1            rising-edge clock
//  reset        in   1            asynchronous, active-low reset
//  IDRs1        in   [0:4]        source reg 1 of instruction in ID
//  IDRs2        in   [0:4]        source reg 2 of instruction in ID
//  IDUsesRs1    in   1            ID instruction reads Rs1
//  IDUsesRs2    in   1            ID instruction reads Rs2
//  EXRd         in   [0:4]        destination reg of instruction in EX
//  EXMemRead    in   1            EX instruction is a load
//  BranchTaken  in   1            ID resolved taken branch/jump (PC mux selects target)
//  IMemReady    in   1            instruction word valid this cycle
//  IMemReq      out  1            fetch request to instruction memory
//  PCWrite      out  1            PC register load enable
//  IFIDWrite    out  1            IF/ID register load enable
//  IFIDFlush    out  1            load NOP into IF/ID (overrides fetched word)
//  IDEXBubble   out  1            load NOP into ID/EX
//  StallCount   out  [0:STALL_CNT_W-1]  saturating count of bubble cycles
//  IMemTimeout  out  1            sticky fetch-timeout error
// BEHAVIOUR
//  States: BOOT, FETCH, WAIT, ERROR. Control outputs are combinational (state, inputs);
//   StallCount, IMemTimeout, wait counter and state are registered.
//  reset low (any time, incl. mid-WAIT): immediately state=BOOT, StallCount=0, wait cnt=0,
//   IMemTimeout=0; BOOT outputs: IMemReq=0 PCWrite=0 IFIDWrite=0 IFIDFlush=1 IDEXBubble=1.
//  BOOT: exactly one cycle after reset release -> FETCH.
//  hazard = EXMemRead & (EXRd!=0) & ((IDUsesRs1 & IDRs1==EXRd) | (IDUsesRs2 & IDRs2==EXRd)).
//  FETCH/WAIT: IMemReq=1. Priority, evaluated in the same cycle:
//   1) !IMemReady: PCWrite=0 IFIDWrite=0 IFIDFlush=0 IDEXBubble=1; next=WAIT.
//   2) hazard: PCWrite=0 IFIDWrite=0 IFIDFlush=0 IDEXBubble=1; next=FETCH.
//   3) BranchTaken: PCWrite=1 IFIDWrite=1 IFIDFlush=1 IDEXBubble=0; next=FETCH.
//   4) else: PCWrite=1 IFIDWrite=1 IFIDFlush=0 IDEXBubble=0; next=FETCH.
//  Hazard beats branch (branch operands not yet valid); branch held in frozen ID is
//   re-applied on the cycle IMemReady arrives; wrong-path word is flushed then.
//  Wait counter: cleared on entry to FETCH; increments each WAIT cycle with !IMemReady.
//   When it reaches MAX_IMEM_WAIT -> ERROR. IMemReady in that same cycle wins (no error).
//  ERROR: IMemReq=0 PCWrite=0 IFIDWrite=0 IFIDFlush=1 IDEXBubble=1, IMemTimeout=1;
//   left only by reset.
//  StallCount: +1 on every FETCH/WAIT cycle with IDEXBubble=1; saturates at all-ones;
//   not incremented in BOOT or ERROR. Unsigned, no wrap.
// TESTING
//  1 reset low 2 cycles, release, IMemReady=1, no hazard -> 1 BOOT cycle (Flush=1), then
//    PCWrite=IFIDWrite=1 every cycle, StallCount=0.
//  2 EXMemRead=1 EXRd=5 IDRs1=5 IDUsesRs1=1 for 1 cycle -> PCWrite=0 IFIDWrite=0
//    IDEXBubble=1, StallCount=1; same with EXRd=0 -> no stall.
//  3 BranchTaken=1 alone -> PCWrite=1 IFIDFlush=1; BranchTaken=1 with hazard -> stall,
//    IFIDFlush=0, then flush on next cycle once hazard clears.
//  4 IMemReady low 3 cycles then high -> 3 bubble cycles, PC/IFID frozen, StallCount+=3,
//    advance on 4th cycle; IMemTimeout stays 0.
//  5 IMemReady held low -> after FETCH + MAX_IMEM_WAIT(15) WAIT cycles state=ERROR,
//    IMemTimeout=1 sticky; reset low mid-WAIT -> BOOT outputs immediately, counters 0.
//  6 STALL_CNT_W=4, 20 consecutive hazard cycles -> StallCount=15 and holds.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Fetch-stage sequencer for the 5-stage DLX pipeline: stalls on load-use and slow imem, flushes on taken branch.
// Control outputs are combinational in (state, inputs); StallCount, IMemTimeout and state are registered.
module pipeline_hazard_ctrl #(
  parameter int STALL_CNT_W   = 16,
  parameter int MAX_IMEM_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [0:4]             IDRs1,
  input  logic [0:4]             IDRs2,
  input  logic                   IDUsesRs1,
  input  logic                   IDUsesRs2,
  input  logic [0:4]             EXRd,
  input  logic                   EXMemRead,
  input  logic                   BranchTaken,
  input  logic                   IMemReady,
  output logic                   IMemReq,
  output logic                   PCWrite,
  output logic                   IFIDWrite,
  output logic                   IFIDFlush,
  output logic                   IDEXBubble,
  output logic [0:STALL_CNT_W-1] StallCount,
  output logic                   IMemTimeout
);

  localparam int WCW = (MAX_IMEM_WAIT < 2) ? 1 : $clog2(MAX_IMEM_WAIT + 1);
  localparam logic [WCW-1:0] LAST_WAIT = WCW'(MAX_IMEM_WAIT - 1);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_ERROR} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [WCW-1:0]         r_wait_cnt;
  logic [0:STALL_CNT_W-1] r_stall;
  logic                   r_timeout;
  logic                   w_hazard;
  logic                   w_active;

  assign w_hazard = EXMemRead && (EXRd != 5'd0) &&
                    ((IDUsesRs1 && (IDRs1 == EXRd)) || (IDUsesRs2 && (IDRs2 == EXRd)));
  assign w_active = (r_state == S_FETCH) || (r_state == S_WAIT);

  always_comb begin
    w_next     = r_state;
    IMemReq    = 1'b0;
    PCWrite    = 1'b0;
    IFIDWrite  = 1'b0;
    IFIDFlush  = 1'b1;
    IDEXBubble = 1'b1;
    case (r_state)
      S_BOOT: w_next = S_FETCH;
      S_FETCH, S_WAIT: begin
        IMemReq   = 1'b1;
        IFIDFlush = 1'b0;
        // A late fetch freezes everything, so a pending branch is simply re-applied once the word arrives.
        if (!IMemReady) begin
          w_next = ((r_state == S_WAIT) && (r_wait_cnt == LAST_WAIT)) ? S_ERROR : S_WAIT;
        end else if (w_hazard) begin
          w_next = S_FETCH;
        end else if (BranchTaken) begin
          PCWrite    = 1'b1;
          IFIDWrite  = 1'b1;
          IFIDFlush  = 1'b1;
          IDEXBubble = 1'b0;
          w_next     = S_FETCH;
        end else begin
          PCWrite    = 1'b1;
          IFIDWrite  = 1'b1;
          IDEXBubble = 1'b0;
          w_next     = S_FETCH;
        end
      end
      default: w_next = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_BOOT;
      r_wait_cnt <= '0;
      r_stall    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_FETCH)
        r_wait_cnt <= '0;
      else if ((r_state == S_WAIT) && !IMemReady)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_active && IDEXBubble && (r_stall != '1))
        r_stall <= r_stall + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      if (w_next == S_ERROR)
        r_timeout <= 1'b1;
    end
  end

  assign StallCount  = r_stall;
  assign IMemTimeout = r_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MAXW = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:4] IDRs1, IDRs2, EXRd;
  logic       IDUsesRs1, IDUsesRs2, EXMemRead, BranchTaken, IMemReady;

  logic        a_req, a_pc, a_ifw, a_fl, a_bub, a_to;
  logic [0:15] a_cnt;
  logic        b_req, b_pc, b_ifw, b_fl, b_bub, b_to;
  logic [0:3]  b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: 0 = booting, 1 = running, 2 = dead after fetch timeout.
  int m_mode, m_miss, m_s16, m_s4;
  bit m_to;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.STALL_CNT_W(16), .MAX_IMEM_WAIT(MAXW)) u_dut (
    .clk(clk), .reset(reset), .IDRs1(IDRs1), .IDRs2(IDRs2), .IDUsesRs1(IDUsesRs1),
    .IDUsesRs2(IDUsesRs2), .EXRd(EXRd), .EXMemRead(EXMemRead), .BranchTaken(BranchTaken),
    .IMemReady(IMemReady), .IMemReq(a_req), .PCWrite(a_pc), .IFIDWrite(a_ifw),
    .IFIDFlush(a_fl), .IDEXBubble(a_bub), .StallCount(a_cnt), .IMemTimeout(a_to));

  pipeline_hazard_ctrl #(.STALL_CNT_W(4), .MAX_IMEM_WAIT(MAXW)) u_sat (
    .clk(clk), .reset(reset), .IDRs1(IDRs1), .IDRs2(IDRs2), .IDUsesRs1(IDUsesRs1),
    .IDUsesRs2(IDUsesRs2), .EXRd(EXRd), .EXMemRead(EXMemRead), .BranchTaken(BranchTaken),
    .IMemReady(IMemReady), .IMemReq(b_req), .PCWrite(b_pc), .IFIDWrite(b_ifw),
    .IFIDFlush(b_fl), .IDEXBubble(b_bub), .StallCount(b_cnt), .IMemTimeout(b_to));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit load_use();
    int srcs[$];
    if (!EXMemRead || EXRd == 0) return 1'b0;
    if (IDUsesRs1) srcs.push_back(int'(IDRs1));
    if (IDUsesRs2) srcs.push_back(int'(IDRs2));
    foreach (srcs[i]) if (srcs[i] == int'(EXRd)) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive, compare at negedge, advance model, land #1 after the next posedge.
  task automatic step(input bit rst_n, input bit rdy, input bit br, input bit ld,
                      input int rd, input int rs1, input int rs2, input bit u1, input bit u2);
    logic [4:0] exp;
    bit stall;
    reset = rst_n; IMemReady = rdy; BranchTaken = br; EXMemRead = ld;
    EXRd = 5'(rd); IDRs1 = 5'(rs1); IDRs2 = 5'(rs2); IDUsesRs1 = u1; IDUsesRs2 = u2;
    if (!rst_n) begin
      m_mode = 0; m_miss = 0; m_s16 = 0; m_s4 = 0; m_to = 0;
    end
    @(negedge clk);
    stall = 1'b0;
    if (m_mode != 1)      exp = 5'b00011;
    else if (!rdy)        begin exp = 5'b10001; stall = 1'b1; end
    else if (load_use())  begin exp = 5'b10001; stall = 1'b1; end
    else if (br)          exp = 5'b11110;
    else                  exp = 5'b11100;
    check("ctl",    {27'd0, a_req, a_pc, a_ifw, a_fl, a_bub}, {27'd0, exp});
    check("ctl_w4", {27'd0, b_req, b_pc, b_ifw, b_fl, b_bub}, {27'd0, exp});
    check("stall",  {16'd0, a_cnt}, 32'(m_s16));
    check("stall_w4", {28'd0, b_cnt}, 32'(m_s4));
    check("timeout", {30'd0, a_to, b_to}, {30'd0, m_to, m_to});
    if (rst_n) begin
      if (m_mode == 0) begin
        m_mode = 1; m_miss = 0;
      end else if (m_mode == 1) begin
        if (stall) begin
          if (m_s16 < 65535) m_s16++;
          if (m_s4 < 15) m_s4++;
        end
        // The fetch that first misses plus MAXW further misses exhaust the patience.
        m_miss = rdy ? 0 : m_miss + 1;
        if (m_miss == MAXW + 1) begin m_mode = 2; m_to = 1'b1; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_mode = 0; m_miss = 0; m_s16 = 0; m_s4 = 0; m_to = 0;
    reset = 1'b0; IMemReady = 1'b1; BranchTaken = 1'b0; EXMemRead = 1'b0;
    EXRd = '0; IDRs1 = '0; IDRs2 = '0; IDUsesRs1 = 1'b0; IDUsesRs2 = 1'b0;

    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(6);
    check("t1_stall", {16'd0, a_cnt}, 32'd0);

    step(1, 1, 0, 1, 5, 5, 0, 1, 0);
    check("t2_stall", {16'd0, a_cnt}, 32'd1);
    step(1, 1, 0, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 7, 3, 7, 1, 0);
    step(1, 1, 0, 1, 7, 3, 7, 0, 1);
    check("t2_rs2_stall", {16'd0, a_cnt}, 32'd2);

    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 9, 9, 0, 1, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    check("t3_stall", {16'd0, a_cnt}, 32'd3);

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    check("t4_stall", {16'd0, a_cnt}, 32'd6);
    check("t4_timeout", {31'd0, a_to}, 32'd0);

    for (int i = 0; i < MAXW + 1; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_timeout", {31'd0, a_to}, 32'd1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("t5_sticky", {31'd0, a_to}, 32'd1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_rst_cnt", {16'd0, a_cnt}, 32'd0);

    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 1, 12, 12, 12, 1, 1);
    check("t6_sat4", {28'd0, b_cnt}, 32'd15);
    check("t6_cnt16", {16'd0, a_cnt}, 32'd20);
    idle(2);

    for (int i = 0; i < 800; i++) begin
      bit rst_n, rdy;
      rst_n = ($urandom_range(0, 59) != 0);
      rdy   = (i % 200 > 180) ? 1'b0 : ($urandom_range(0, 4) != 0);
      step(rst_n, rdy, 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
